// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : req/done sequencer between datapath and word-addressed memory;
//             sub-word loads with sign extension, sub-word stores by RMW.
//             Optional macro: MEM_ALIGN_CHECK_EN (misaligned abort with err).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_lane;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_merge;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_mem_a;
    logic          w_misaligned;
    logic          w_req_sub;
    logic          w_sub;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_load;
    logic [DW-1:0] w_merge;

    assign w_req_sub = (req_size == c_SZ_BYTE) || (req_size == c_SZ_HALF);
    assign w_sub     = (r_size == c_SZ_BYTE) || (r_size == c_SZ_HALF);

`ifdef MEM_ALIGN_CHECK_EN
    logic r_err;
    // size 2'b11 is handled as a word, so req_size[1] covers both word codes
    assign w_misaligned = ((req_size == c_SZ_HALF) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
    assign err = r_err;
`else
    assign w_misaligned = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        mem_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    if (w_misaligned)              w_next = S_DONE;
                    else if (!req_we || w_req_sub) w_next = S_RD;
                    else                           w_next = S_WR;
                end
            end
            S_RD:    w_next = r_we ? S_WR : S_DONE;
            S_WR: begin
                mem_we = 1'b1;
                w_next = S_DONE;
            end
            default: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    // Load lane extraction, little-endian byte numbering
    always_comb begin
        case (r_lane)
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            2'd3:    w_byte = mem_rd[31:24];
            default: w_byte = mem_rd[7:0];
        endcase
        w_half = r_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (r_size)
            c_SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
            default:   w_load = mem_rd;
        endcase
    end

    always_comb begin
        w_merge = r_merge;
        if (r_size == c_SZ_BYTE) begin
            case (r_lane)
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                2'd3:    w_merge[31:24] = r_wdata[7:0];
                default: w_merge[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lane   <= 2'b00;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_mem_a  <= '0;
        end else begin
            if ((r_state == S_IDLE) && req) begin
                r_lane   <= req_addr[1:0];
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_wdata  <= req_wdata;
                // aborted requests never touch memory, so mem_a keeps its value
                if (!w_misaligned) r_mem_a <= {req_addr[AW-1:2], 2'b00};
            end
            if (r_state == S_RD) begin
                if (r_we) r_merge <= mem_rd;
                else      r_rdata <= w_load;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && req) begin
            r_err <= w_misaligned;
        end else if (r_state == S_DONE) begin
            r_err <= 1'b0;
        end
    end
`endif

    assign rdata  = r_rdata;
    assign mem_a  = r_mem_a;
    assign mem_wd = (r_state == S_WR) ? (w_sub ? w_merge : r_wdata) : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : self-checking bench for mem_access_unit with a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_val = 32'd0;

    typedef struct {
        bit          is_load;
        int          idx;
        logic [31:0] val;
    } sb_t;
    sb_t sb_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_a[9:2]];

    always @(posedge clk) begin
        if (pl_en)       mem[pl_idx] <= pl_val;
        else if (mem_we) mem[mem_a[9:2]] <= mem_wd;
    end

    function automatic logic [31:0] load_exp(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic s);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        if (sz == 2'b00)      return s ? {{24{b[7]}}, b} : {24'd0, b};
        else if (sz == 2'b01) return s ? {{16{h[15]}}, h} : {16'd0, h};
        else                  return w;
    endfunction

    function automatic logic [31:0] store_exp(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00)      r[8*a[1:0] +: 8] = d[7:0];
        else if (sz == 2'b01) r[16*a[1] +: 16] = d[15:0];
        else                  r = d;
        return r;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx[7:0]; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic access(input string name, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input bit mis, input int exp_lat, input int exp_we);
        sb_t e;
        sb_t got_e;
        int  lat;
        int  wecnt;
        bit  got;
        logic err_seen;
        e.idx = int'(a[9:2]);
        if (mis) begin
            e.is_load = 1'b1; e.val = exp_rdata;
        end else if (!we) begin
            e.is_load = 1'b1; e.val = load_exp(ref_mem[e.idx], a, sz, sg);
            exp_rdata = e.val;
        end else begin
            e.is_load = 1'b0; e.val = store_exp(ref_mem[e.idx], a, sz, wd);
            ref_mem[e.idx] = e.val;
        end
        sb_q.push_back(e);

        @(negedge clk);
        req = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
        lat = 1; wecnt = 0; got = 1'b0; err_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mem_we) wecnt++;
            if (done) begin
                got = 1'b1; err_seen = err;
                break;
            end
            lat++;
            @(negedge clk);
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL %s done_timeout: no done within 8 cycles", name);
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (wecnt !== exp_we) begin
            n_fail++; $display("FAIL %s mem_we_cycles: got %0d expected %0d", name, wecnt, exp_we);
        end
        n_checks++;
        if (err_seen !== mis) begin
            n_fail++; $display("FAIL %s err: got %b expected %b", name, err_seen, mis);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_in_done: got %b expected 1", name, busy);
        end
        got_e = sb_q.pop_front();
        n_checks++;
        if (got_e.is_load && rdata !== got_e.val) begin
            n_fail++; $display("FAIL %s rdata: got %h expected %h", name, rdata, got_e.val);
        end else if (!got_e.is_load && mem[got_e.idx] !== got_e.val) begin
            n_fail++; $display("FAIL %s mem_word: got %h expected %h", name, mem[got_e.idx], got_e.val);
        end
        if (!got_e.is_load) begin
            n_checks++;
            if (rdata !== exp_rdata) begin
                n_fail++; $display("FAIL %s rdata_kept: got %h expected %h", name, rdata, exp_rdata);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s after_done: done=%b busy=%b expected 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err, mem_we} !== 4'b0000 || rdata !== 32'd0 ||
            mem_a !== 32'd0 || mem_wd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b err=%b we=%b rdata=%h a=%h wd=%h expected all 0",
                     busy, done, err, mem_we, rdata, mem_a, mem_wd);
        end
        req = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_hold: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_loads();
        preload(4, 32'h8765_43A1);
        access("load_word",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 2, 0);
        access("load_b0_s",   1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 2, 0);
        access("load_b3_u",   1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 2, 0);
        access("load_h2_s",   1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 2, 0);
        access("load_h0_u",   1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 2, 0);
        access("load_b1_s",   1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 2, 0);
        access("load_rsv_sz", 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1'b0, 2, 0);
    endtask

    task automatic test_stores();
        preload(4, 32'h1122_3344);
        access("store_byte", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 1'b0, 3, 1);
        access("store_half", 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_CAFE, 1'b0, 3, 1);
        access("store_word", 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEAD_BEEF, 1'b0, 2, 1);
        access("load_back",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 2, 0);
    endtask

    task automatic test_busy_ignore();
        int dones;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h14;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) begin
                dones++;
                req = 1'b0;
            end
            @(negedge clk);
        end
        req = 1'b0;
        exp_rdata = ref_mem[4];
        n_checks++;
        if (dones !== 1) begin
            n_fail++; $display("FAIL busy_ignore_dones: got %0d expected 1", dones);
        end
        n_checks++;
        if (rdata !== exp_rdata) begin
            n_fail++; $display("FAIL busy_ignore_rdata: got %h expected %h", rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_abort();
        int wecnt;
        preload(8, 32'h5566_7788);
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h21; req_wdata = 32'h99;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        wecnt = mem_we ? 1 : 0;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, mem_we} !== 4'b0000 || rdata !== 32'd0 ||
            mem_a !== 32'd0 || mem_wd !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b done=%b err=%b we=%b rdata=%h a=%h wd=%h expected all 0",
                     busy, done, err, mem_we, rdata, mem_a, mem_wd);
        end
        repeat (3) begin
            @(negedge clk);
            if (mem_we) wecnt++;
        end
        n_checks++;
        if (wecnt !== 0 || mem[8] !== 32'h5566_7788) begin
            n_fail++; $display("FAIL abort_mem: we_cycles=%0d word=%h expected 0 and 55667788", wecnt, mem[8]);
        end
        reset = 1'b1;
        exp_rdata = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_align();
        preload(4, 32'h8765_43A1);
`ifdef MEM_ALIGN_CHECK_EN
        access("align_word_12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1, 0);
        access("align_half_11", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1'b1, 1, 0);
        access("align_st_13",   1'b1, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1, 1, 0);
        n_checks++;
        if (mem[4] !== 32'h8765_43A1) begin
            n_fail++; $display("FAIL align_mem_untouched: got %h expected 876543a1", mem[4]);
        end
`else
        access("align_word_12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0, 2, 0);
        access("align_half_11", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1'b0, 2, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_busy_ignore();
        test_reset_abort();
        test_align();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
